// File: rtl/bitwise_alu_unit_if.sv
// Operand/result bundle for the execute-stage ALU. The master drives operands
// and control; the slave (the ALU) returns the registered result and flags.
interface bitwise_alu_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, A, B, cntrl,
    input  out_valid, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, A, B, cntrl,
    output out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/bitwise_alu_unit.sv
// Registered ripple-carry ALU: a chain of 1-bit slices feeding a result mux,
// zero detector and N/Z/V/C flag logic, all captured in output flops.
module bitwise_alu_unit #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  bitwise_alu_unit_if.slave bus
);

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  // One slice of the adder: returns {cout, sum} for a bit pair and carry-in.
  function automatic logic [1:0] alu_slice(
    input logic a,
    input logic bb,
    input logic cin
  );
    alu_slice = {(a & bb) | (a & cin) | (bb & cin), a ^ bb ^ cin};
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             carry_msb_in_s;
  logic [1:0]       slice_s;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d,    result_q;
  logic             negative_d,  negative_q;
  logic             zero_d,      zero_q;
  logic             overflow_d,  overflow_q;
  logic             carry_out_d, carry_out_q;

  // Ripple carry chain; cntrl[0] both inverts B and injects the +1 for subtract.
  always_comb begin
    sum_s          = {WIDTH{1'b0}};
    carry_s        = bus.cntrl[0];
    carry_msb_in_s = 1'b0;
    slice_s        = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      carry_msb_in_s = carry_s;
      slice_s        = alu_slice(bus.A[i], bus.B[i] ^ bus.cntrl[0], carry_s);
      sum_s[i]       = slice_s[0];
      carry_s        = slice_s[1];
    end
  end

  // Result select and flag generation; carry-in of the MSB slice is cout[WIDTH-2].
  always_comb begin
    out_valid_d = bus.in_valid;
    result_d    = {WIDTH{1'b0}};
    carry_out_d = 1'b0;
    overflow_d  = 1'b0;
    case (bus.cntrl)
      OP_PASS_B: result_d = bus.B;
      OP_ADD, OP_SUB: begin
        result_d    = sum_s;
        carry_out_d = carry_s;
        overflow_d  = carry_s ^ carry_msb_in_s;
      end
      OP_AND:    result_d = bus.A & bus.B;
      OP_OR:     result_d = bus.A | bus.B;
      OP_XOR:    result_d = bus.A ^ bus.B;
      default:   result_d = {WIDTH{1'b0}};
    endcase
    negative_d = result_d[WIDTH-1];
    zero_d     = ~(|result_d);
  end

  // Output registers load every cycle; out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_bitwise_alu_unit.sv
// Scoreboard bench for bitwise_alu_unit: directed corner vectors plus random
// traffic, checked against an arithmetic reference model.
module tb_bitwise_alu_unit;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] r;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;
  exp_t sb_q[$];

  bitwise_alu_unit_if #(.WIDTH(W)) bus ();

  bitwise_alu_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the operation definitions with plain arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op);
    exp_t       e;
    logic [W:0] wide;
    e = '0;
    case (op)
      3'b000: e.r = b;
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        e.r  = wide[W-1:0];
        e.c  = wide[W];
        e.v  = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b011: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b100: e.r = a & b;
      3'b101: e.r = a | b;
      3'b110: e.r = a ^ b;
      default: e.r = '0;
    endcase
    e.n = e.r[W-1];
    e.z = (e.r == '0);
    return e;
  endfunction

  // Monitor: every valid output must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t got;
    exp_t exp_v;
    if (bus.out_valid === 1'b1) begin
      got = {bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out};
      n_vec++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got result=%h nzvc=%b%b%b%b, required no output",
                 got.r, got.n, got.z, got.v, got.c);
      end else begin
        exp_v = sb_q.pop_front();
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL alu_output: got result=%h nzvc=%b%b%b%b, required result=%h nzvc=%b%b%b%b",
                   got.r, got.n, got.z, got.v, got.c,
                   exp_v.r, exp_v.n, exp_v.z, exp_v.v, exp_v.c);
        end
      end
    end
  end

  task automatic apply(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.cntrl    = op;
    @(posedge clk);
    if (v && !reset) sb_q.push_back(model(a, b, op));
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    logic [W+4:0] got;
    got = {bus.out_valid, bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out};
    n_vec++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: got out_valid=%b result=%h nzvc=%b%b%b%b, required all zero",
               tag, bus.out_valid, bus.result, bus.negative, bus.zero,
               bus.overflow, bus.carry_out);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] x;
    case ($urandom_range(0, 7))
      0:       x = '0;
      1:       x = {1'b1, {(W-1){1'b0}}};
      2:       x = {1'b0, {(W-1){1'b1}}};
      3:       x = {W{1'b1}};
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pat_a;
    logic [W-1:0] pat_b;
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.cntrl    = 3'b000;

    apply(1'b1, 64'd7, 64'd9, 3'b010);
    apply(1'b1, 64'd7, 64'd9, 3'b010);
    check_reset_state("reset_state");
    reset = 1'b0;

    apply(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    apply(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b011);
    apply(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    apply(1'b1, 64'h8000_0000_0000_0000, 64'd0, 3'b000);
    apply(1'b1, 64'd0, 64'h8000_0000_0000_0000, 3'b000);
    pat_a = 64'hF0F0_F0F0_F0F0_F0F0;
    pat_b = 64'hFF00_FF00_FF00_FF00;
    apply(1'b1, pat_a, pat_b, 3'b100);
    apply(1'b1, pat_a, pat_b, 3'b101);
    apply(1'b1, pat_a, pat_b, 3'b110);
    apply(1'b1, 64'h8000_0000_0000_0000, 64'd1, 3'b011);
    apply(1'b1, 64'd3, 64'd5, 3'b011);
    apply(1'b1, pat_a, pat_b, 3'b001);
    apply(1'b1, 64'd2, 64'd3, 3'b111);
    apply(1'b1, 64'd2, 64'd3, 3'b010);
    apply(1'b0, 64'd0, 64'd0, 3'b000);

    apply(1'b1, 64'd11, 64'd4, 3'b011);
    reset = 1'b1;
    apply(1'b1, 64'd9, 64'd1, 3'b010);
    check_reset_state("reset_midstream");
    reset = 1'b0;
    apply(1'b1, 64'd5, 64'd3, 3'b011);
    apply(1'b0, 64'd0, 64'd0, 3'b000);

    for (int i = 0; i < 400; i++) begin
      a = rand_operand();
      b = rand_operand();
      apply(($urandom_range(0, 9) != 0), a, b, 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 3; i++) apply(1'b0, 64'd0, 64'd0, 3'b000);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results still pending, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_alu_unit.md
Name: bitwise_alu_unit

Overview:
- Registered N-bit ripple-carry ALU built from a chain of per-bit slices.
- Each slice takes one bit of A and B, a carry-in and the shared 3-bit control, and produces a result bit and a carry-out.
- A full-width zero detector and flag logic (negative, zero, overflow, carry_out) sit on the result.
- All outputs are registered. The block serves as the execute-stage ALU of the pipelined CPU.

Parameters:
- WIDTH, 64, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and cntrl are valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cntrl  input  3  operation select.
- out_valid  output  1  registered copy of in_valid.
- result  output  WIDTH  registered result.
- negative  output  1  registered result[WIDTH-1].
- zero  output  1  registered; 1 when all WIDTH result bits are 0.
- overflow  output  1  registered signed overflow.
- carry_out  output  1  registered carry out of the MSB slice.

Behaviour:
- cntrl encoding:
  - 000 pass B
  - 010 A+B
  - 011 A-B
  - 100 A AND B
  - 101 A OR B
  - 110 A XOR B
  - 001 and 111 are reserved.
- Reserved codes: result = 0, so zero = 1 and negative = overflow = carry_out = 0.
- Slice i:
  - Bb = B[i] XOR cntrl[0].
  - Sum = A[i] ^ Bb ^ cin.
  - cout = majority(A[i], Bb, cin).
  - Result bit is muxed by cntrl.
- Carry chain:
  - Slice 0 cin = cntrl[0], so subtract is A + ~B + 1.
  - Slice i cin = cout of slice i-1 (ripple).
  - Intermediate carries are computed for every opcode.
- Flags:
  - carry_out = cout[WIDTH-1] for add/sub; 0 for all other codes.
  - overflow = cout[WIDTH-1] XOR cout[WIDTH-2] for add/sub; 0 for all other codes.
  - negative = result[WIDTH-1] for every code.
  - zero = NOR over all WIDTH result bits. The MSB is included; there is no masking.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on outputs after edge k.
- No backpressure; a new operation may be accepted every cycle.
- Output registers load every cycle regardless of in_valid; out_valid qualifies them.
- Reset: at a rising edge with reset = 1, all outputs go to 0 (out_valid = 0, result = 0, all flags = 0). Any in-flight operation is discarded.
- Reset has priority over in_valid in the same cycle. The first valid output appears one cycle after the first in_valid sampled with reset low.
- No X propagation from reserved codes; the implementation has no combinational loops and no gate delays.

Test Plan:
- Add with signed overflow (WIDTH=64): A=0x7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010, in_valid=1 -> next cycle: result=0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0, out_valid=1.
- Subtract to zero: A=B=0x1234_5678_9ABC_DEF0, cntrl=011 -> result=0, zero=1, carry_out=1, overflow=0, negative=0.
- Unsigned wrap and MSB-only zero check:
  - A=0xFFFF_FFFF_FFFF_FFFF, B=1, cntrl=010 -> result=0, zero=1, carry_out=1, overflow=0.
  - A=0x8000_0000_0000_0000, B=0, cntrl=000 -> result=0, zero=1.
  - A=0, B=0x8000_0000_0000_0000, cntrl=000 -> result=0x8000_0000_0000_0000, zero=0, negative=1.
- Logic ops: A=0xF0F0_F0F0_F0F0_F0F0, B=0xFF00_FF00_FF00_FF00:
  - AND -> 0xF000_F000_F000_F000.
  - OR -> 0xFFF0_FFF0_FFF0_FFF0.
  - XOR -> 0x0FF0_0FF0_0FF0_0FF0.
  - For all three: carry_out = overflow = 0.
- Reserved code and back-to-back: cntrl=111 then cntrl=010 with A=2, B=3 on consecutive cycles -> result 0 (zero=1), then 5 on the following cycle, one result per cycle.
- Reset mid-stream: assert reset together with in_valid=1 -> outputs all 0 and out_valid=0 after that edge. Deassert reset, apply A=5, B=3, cntrl=011 -> result=2, out_valid=1 one cycle later.
